// File: rtl/regfile_pkg.sv
// Register file shared definitions, also used by the read mux and the register array.
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int REG_N  = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping upward.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id
);

  // Walk NREQ slots starting at ptr; the first hit is the only grant.
  always_comb begin
    logic found;
    int   idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// Shares the register file read mux among NREQ clients: grant, select, then return data.
module regread_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  input  logic              stall,
  output logic [AW-1:0]     reg_no,
  input  logic [DW-1:0]     regData,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_id;
  logic [NREQ-1:0] gnt;
  logic            hs;
  logic            s_valid;
  logic [IW-1:0]   s_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Stall and reset both suppress the grant; a stalled request just waits.
  assign req_ready = (reset || stall) ? '0 : gnt;
  assign hs        = |req_ready;

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rr_ptr <= '0;
    else if (hs) rr_ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
  end

  // Select stage: latch the winner's address; reg_no holds when idle to keep the mux quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_no  <= '0;
      s_valid <= 1'b0;
      s_id    <= '0;
    end else if (!stall) begin
      s_valid <= hs;
      if (hs) begin
        reg_no <= req_addr[int'(gnt_id)*AW +: AW];
        s_id   <= gnt_id;
      end
    end
  end

  // Response stage: capture mux output (r0 forced to zero when enabled) and strobe the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else if (!stall) begin
      rsp_data  <= (ZERO_R0 && reg_no == '0) ? '0 : regData;
      rsp_valid <= s_valid ? (NREQ'(1) << s_id) : '0;
    end
  end

endmodule

// File: tb/tb_regread_arbiter.sv
// Randomized + directed bench for regread_arbiter with a queue-based scoreboard.
module tb_regread_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     reg_no;
  logic [DW-1:0]     regData;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;

  logic [DW-1:0] mem [32];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            ptr = 0;
  int            nsc = 0;
  int            g;
  logic [AW-1:0] a;
  logic [AW-1:0] exp_reg = '0;

  always #5 clk = ~clk;

  // Mux model: pure combinational lookup of the selected register.
  assign regData = mem[reg_no];

  regread_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_R0(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .stall     (stall),
    .reg_no    (reg_no),
    .regData   (regData),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor: check outputs, then predict the coming edge.
  // nsc counts non-stalled edges; a response is due two non-stalled edges after
  // its handshake is decided and persists while stalled.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      ptr     = 0;
      exp_reg = '0;
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_data",  64'(rsp_data),  64'(0));
      chk("reset_reg_no",    64'(reg_no),    64'(0));
    end else begin
      chk("reg_no", 64'(reg_no), 64'(exp_reg));
      if (q.size() > 0 && q[0].due == nsc) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << q[0].id);
        chk("rsp_data",  64'(rsp_data),  64'(q[0].data));
        if (!stall) void'(q.pop_front());
      end else begin
        chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      g = -1;
      if (!stall)
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (ptr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      chk("req_ready", 64'(req_ready), (g < 0) ? 64'(0) : (64'(1) << g));
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        q.push_back(exp_t'{g, (a == 0) ? 32'h0 : mem[a], nsc + 2});
        ptr     = (g + 1) % NREQ;
        exp_reg = a;
      end
      if (!stall) nsc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] addr);
    req_valid[id]           = 1'b1;
    req_addr[id*AW +: AW]   = addr;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'hFFFF_FFFF;
    mem[7] = 32'hDEAD_0007;

    // Reset held three cycles, then idle.
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Single read: requester 2 reads r7.
    set_req(2, 5'd7);
    step();
    req_valid = '0;
    repeat (3) step();

    // Round robin with everybody asking.
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < NREQ; r++) set_req(r, AW'($urandom_range(1, 31)));
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // Register 0 reads as zero while the mux drives all ones.
    set_req(1, 5'd0);
    step();
    req_valid = '0;
    repeat (3) step();

    // Stall while a response sits in the response stage, with requests pending.
    set_req(0, 5'd5);
    step();
    req_valid = '0;
    step();
    stall = 1'b1;
    for (int r = 0; r < NREQ; r++) set_req(r, AW'(r + 10));
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();

    // Reset between handshake and response; first grant after goes to lowest valid.
    set_req(3, 5'd9);
    step();
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) step();
    reset = 1'b0;
    set_req(1, 5'd12);
    set_req(3, 5'd13);
    step();
    req_valid = '0;
    repeat (3) step();

    // Random traffic with stalls and occasional resets.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      stall     = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    req_valid = '0;
    stall     = 1'b0;
    reset     = 1'b0;
    repeat (5) step();

    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
